fp_comp_pipe: RTL and testbench
===============================

Name: fp_comp_pipe

Overview:
- Parametrised, two-stage pipelined IEEE-754 comparator and min/max unit; the next generation of the single-precision comparator.
- Exponent and mantissa widths are parameters, so one block serves half, single and double precision.
- Provides ordered/unordered compare, signalling compare, MIN and MAX on one datapath.
- Accepts one operation per cycle with no stalls. Sits beside the adder/multiplier in the FPU execute stage and shares its act/done handshake.

Parameters:
- EXP_W, 8, exponent field width
- MAN_W, 23, stored mantissa (fraction) width
- W, 1+EXP_W+MAN_W, operand width (derived; not for override)

Ports:
- clk  input  1  clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- act  input  1  operation valid this cycle
- op  input  2  00 CMPQ quiet compare, 01 CMPS signalling compare, 10 MIN, 11 MAX
- in1  input  W  operand A
- in2  input  W  operand B
- eq  output  1  A == B (ordered)
- less  output  1  A < B (ordered)
- great  output  1  A > B (ordered)
- unord  output  1  at least one operand is NaN
- inv  output  1  invalid-operation exception
- res  output  W  MIN/MAX result; zero for compare ops
- done  output  1  one-cycle pulse: outputs valid

Behaviour:
- Reset (rst=1, async):
  - all outputs 0; both pipeline valid bits 0.
  - In-flight operations are discarded and produce no done.
  - The first act is accepted on the first clk edge after rst falls.
- Latency and throughput:
  - act sampled at edge N produces done=1 after edge N+2.
  - Full throughput: act high for k consecutive cycles gives k consecutive done pulses, in order.
  - No back-pressure.
- Output holding: eq/less/great/unord/inv/res update only on the edge that raises done, and hold their values otherwise.
- Stage 1 (register on act):
  - Classify each operand: NaN = exponent all ones and fraction != 0; sNaN = NaN with fraction MSB 0; Inf = exponent all ones and fraction 0; zero = exponent and fraction 0.
  - Register the operands, op and class bits.
- Stage 2:
  - Sign-magnitude ordering; magnitude = {exponent, fraction}, compared unsigned.
  - Both negative: magnitude order reversed.
  - +0 and -0 compare equal.
  - Infinities are ordered normally: -Inf < every finite value < +Inf, and Inf == Inf of the same sign.
  - Denormals compare by value.
- Exactly one of eq/less/great is 1 when unord=0. All three are 0 when unord=1.
- inv = (either operand sNaN) OR (op=CMPS AND unord). inv=0 for a quiet NaN under CMPQ/MIN/MAX.
- res for MIN/MAX:
  - smaller (MIN) or larger (MAX) operand, bit-exact.
  - Equal operands: returns in1.
  - Zeros of opposite sign: MIN returns -0, MAX returns +0.
  - Exactly one operand NaN: returns the other operand.
  - Both NaN: canonical qNaN = sign 0, exponent all ones, fraction MSB 1, rest 0.
  - Compare flags are still driven for MIN/MAX.
- res = 0 for CMPQ/CMPS.
- act=0: the stage valid bit clears; datapath registers may hold stale data, and outputs do not change.

Optional Feature:
- Macro: FP_COMP_DAZ_EN.
- Defined (denormals-are-zero):
  - Any operand with exponent 0 is treated as a zero of its sign for ordering.
  - MIN/MAX returns the original operand bits, not a flushed value.
  - Two denormals of any value compare eq=1.
- Undefined: denormals are ordered by exact value. No extra logic is generated.

Test Plan:
- CMPQ in1=3F800000 (1.0), in2=40000000 (2.0), act at edge 0 -> after edge 2: done=1, less=1, eq=0, great=0, unord=0, inv=0. done=0 the following cycle with flags held.
- CMPQ 00000000 vs 80000000 -> eq=1. MIN same pair -> res=80000000. MAX same pair -> res=00000000. CMPQ FF800000 vs FF7FFFFF -> less=1.
- CMPQ 7FC00000 vs 3F800000 -> unord=1, inv=0. CMPS same pair -> unord=1, inv=1. CMPQ 7F800001 vs 3F800000 -> inv=1. MIN 7FC00000, 3F800000 -> res=3F800000. MAX 7FC00000, FFC00000 -> res=7FC00000.
- Three consecutive act cycles: CMPQ 1.0 vs 1.0, MAX C0000000 vs 3F800000, CMPQ BF800000 vs C0000000 -> done high three consecutive cycles, giving eq=1; then res=3F800000; then great=1.
- rst pulsed high one cycle after act with op in flight -> all outputs 0 immediately and no done. A new act after release -> done exactly 2 edges later.
- EXP_W=11, MAN_W=52: CMPQ 0000000000000001 vs 0000000000000000 -> great=1 without FP_COMP_DAZ_EN, eq=1 with it.

Source files
------------

// File: rtl/fp_comp_pipe_if.sv
// Handshake and operand/result bundle for the fp_comp_pipe comparator.
// The master drives operations, the slave (comparator) returns flags and result.
interface fp_comp_pipe_if #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
);
  localparam int unsigned W = 1 + EXP_W + MAN_W;

  logic         act;
  logic [1:0]   op;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         eq;
  logic         less;
  logic         great;
  logic         unord;
  logic         inv;
  logic [W-1:0] res;
  logic         done;

  modport master (
    output act, op, in1, in2,
    input  eq, less, great, unord, inv, res, done
  );

  modport slave (
    input  act, op, in1, in2,
    output eq, less, great, unord, inv, res, done
  );
endinterface

// File: rtl/fp_comp_pipe.sv
// Parametrised pipelined IEEE-754 compare / MIN / MAX unit: act at edge N gives done after N+2.
// Optional macro FP_COMP_DAZ_EN: operands with a zero exponent order as zeros of their sign.
module fp_comp_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input logic           clk,
  input logic           rst,
  fp_comp_pipe_if.slave bus
);
  localparam int unsigned W = 1 + EXP_W + MAN_W;
  localparam logic [1:0] OpCmpS = 2'b01;
  localparam logic [W-1:0] CanonNan = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};

  typedef struct packed {
    logic nan;
    logic snan;
    logic zero;
  } cls_t;

  function automatic cls_t classify(input logic [W-1:0] x);
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] f;
    cls_t             c;
    e      = x[W-2:MAN_W];
    f      = x[MAN_W-1:0];
    c.nan  = (&e) & (|f);
    c.snan = (&e) & (|f) & ~f[MAN_W-1];
`ifdef FP_COMP_DAZ_EN
    c.zero = ~|e;
`else
    c.zero = ~|e & ~|f;
`endif
    return c;
  endfunction

  // Stage 1: operands, op and class bits
  logic         v1_q;
  logic [1:0]   op1_q;
  logic [W-1:0] a1_q, b1_q;
  cls_t         ca1_q, cb1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q  <= 1'b0;
      op1_q <= '0;
      a1_q  <= '0;
      b1_q  <= '0;
      ca1_q <= '0;
      cb1_q <= '0;
    end else begin
      v1_q <= bus.act;
      if (bus.act) begin
        op1_q <= bus.op;
        a1_q  <= bus.in1;
        b1_q  <= bus.in2;
        ca1_q <= classify(bus.in1);
        cb1_q <= classify(bus.in2);
      end
    end
  end

  // Stage 2: sign-magnitude ordering
  logic         sa, sb, unord_c, inv_c, eq_c, lt_c, gt_c;
  logic [W-2:0] ma, mb;

  assign sa      = a1_q[W-1];
  assign sb      = b1_q[W-1];
  assign ma      = ca1_q.zero ? '0 : a1_q[W-2:0];
  assign mb      = cb1_q.zero ? '0 : b1_q[W-2:0];
  assign unord_c = ca1_q.nan | cb1_q.nan;
  assign inv_c   = ca1_q.snan | cb1_q.snan | ((op1_q == OpCmpS) & unord_c);

  always_comb begin
    eq_c = 1'b0;
    lt_c = 1'b0;
    gt_c = 1'b0;
    if (!unord_c) begin
      if (ca1_q.zero && cb1_q.zero) begin
        eq_c = 1'b1;
      end else if (sa != sb) begin
        lt_c = sa;
        gt_c = sb;
      end else if (ma == mb) begin
        eq_c = 1'b1;
      end else if ((ma < mb) ^ sa) begin
        lt_c = 1'b1;
      end else begin
        gt_c = 1'b1;
      end
    end
  end

  logic         v2_q, eq2_q, lt2_q, gt2_q, un2_q, inv2_q, na2_q, nb2_q;
  logic [1:0]   op2_q;
  logic [W-1:0] a2_q, b2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q   <= 1'b0;
      eq2_q  <= 1'b0;
      lt2_q  <= 1'b0;
      gt2_q  <= 1'b0;
      un2_q  <= 1'b0;
      inv2_q <= 1'b0;
      na2_q  <= 1'b0;
      nb2_q  <= 1'b0;
      op2_q  <= '0;
      a2_q   <= '0;
      b2_q   <= '0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        eq2_q  <= eq_c;
        lt2_q  <= lt_c;
        gt2_q  <= gt_c;
        un2_q  <= unord_c;
        inv2_q <= inv_c;
        na2_q  <= ca1_q.nan;
        nb2_q  <= cb1_q.nan;
        op2_q  <= op1_q;
        a2_q   <= a1_q;
        b2_q   <= b1_q;
      end
    end
  end

  // Result select; op bit 0 distinguishes MAX from MIN
  logic [W-1:0] res_c;

  always_comb begin
    res_c = '0;
    if (op2_q[1]) begin
      if (na2_q && nb2_q) begin
        res_c = CanonNan;
      end else if (na2_q) begin
        res_c = b2_q;
      end else if (nb2_q) begin
        res_c = a2_q;
      end else if (lt2_q) begin
        res_c = op2_q[0] ? b2_q : a2_q;
      end else if (gt2_q) begin
        res_c = op2_q[0] ? a2_q : b2_q;
      end else if (a2_q[W-1] != b2_q[W-1]) begin
        res_c = (a2_q[W-1] ^ op2_q[0]) ? a2_q : b2_q;
      end else begin
        res_c = a2_q;
      end
    end
  end

  logic         done_q, eq_q, less_q, great_q, unord_q, inv_q;
  logic [W-1:0] res_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q  <= 1'b0;
      eq_q    <= 1'b0;
      less_q  <= 1'b0;
      great_q <= 1'b0;
      unord_q <= 1'b0;
      inv_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      done_q <= v2_q;
      if (v2_q) begin
        eq_q    <= eq2_q;
        less_q  <= lt2_q;
        great_q <= gt2_q;
        unord_q <= un2_q;
        inv_q   <= inv2_q;
        res_q   <= res_c;
      end
    end
  end

  assign bus.done  = done_q;
  assign bus.eq    = eq_q;
  assign bus.less  = less_q;
  assign bus.great = great_q;
  assign bus.unord = unord_q;
  assign bus.inv   = inv_q;
  assign bus.res   = res_q;
endmodule

// File: tb/tb_fp_comp_pipe.sv
// Self-checking bench for fp_comp_pipe: directed table, reset-in-flight, random vs real-valued model.
// Expectations follow FP_COMP_DAZ_EN when the bench is built with it.
module tb_fp_comp_pipe;
  typedef struct packed {
    logic        eq;
    logic        less;
    logic        great;
    logic        unord;
    logic        inv;
    logic [31:0] res;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    exp_t        e;
    int          gap;
  } vec_t;

  typedef struct {
    int   due;
    exp_t e;
  } sb_t;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  exp_t last;
  sb_t  sb[$];
  vec_t tbl[$];

  fp_comp_pipe_if #(.EXP_W(8), .MAN_W(23)) bus ();
  fp_comp_pipe_if #(.EXP_W(11), .MAN_W(52)) dbus ();

  fp_comp_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  fp_comp_pipe #(.EXP_W(11), .MAN_W(52)) dut_d (
    .clk (clk),
    .rst (rst),
    .bus (dbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic check_out(input string tag, input exp_t e);
    check({tag, ".eq"}, 64'(bus.eq), 64'(e.eq));
    check({tag, ".less"}, 64'(bus.less), 64'(e.less));
    check({tag, ".great"}, 64'(bus.great), 64'(e.great));
    check({tag, ".unord"}, 64'(bus.unord), 64'(e.unord));
    check({tag, ".inv"}, 64'(bus.inv), 64'(e.inv));
    check({tag, ".res"}, 64'(bus.res), 64'(e.res));
  endtask

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Real value of an operand; infinities map beyond any finite single value
  function automatic real to_val(input logic [31:0] x);
    int  e;
    real m;
    e = int'(x[30:23]);
    if (e == 255) m = 1.0e300;
`ifdef FP_COMP_DAZ_EN
    else if (e == 0) m = 0.0;
`else
    else if (e == 0) m = real'(x[22:0]) * (2.0 ** (-149));
`endif
    else m = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** (e - 127));
    return x[31] ? -m : m;
  endfunction

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    logic na, nb;
    real  va, vb;
    r  = '0;
    na = is_nan(a);
    nb = is_nan(b);
    va = to_val(a);
    vb = to_val(b);
    r.unord = na | nb;
    r.inv   = (na & ~a[22]) | (nb & ~b[22]) | ((op == 2'd1) & r.unord);
    if (!r.unord) begin
      r.eq    = (va == vb);
      r.less  = (va < vb);
      r.great = (va > vb);
    end
    if (op[1]) begin
      if (na && nb) r.res = 32'h7FC00000;
      else if (na) r.res = b;
      else if (nb) r.res = a;
      else if (va < vb) r.res = (op == 2'd2) ? a : b;
      else if (va > vb) r.res = (op == 2'd2) ? b : a;
      else if (a[31] != b[31]) r.res = ((op == 2'd2) == a[31]) ? a : b;
      else r.res = a;
    end
    return r;
  endfunction

  function automatic logic [31:0] rnd_operand(input logic [31:0] other);
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 9))
      1: x = {x[31], 31'd0};
      2: x = {x[31], 8'hFF, 23'd0};
      3: x = {x[31], 8'hFF, 1'b1, x[21:0]};
      4: x = {x[31], 8'hFF, 1'b0, x[21:1], 1'b1};
      5: x = {x[31], 8'h00, x[22:0]};
      6: x = other;
      7: x = {~other[31], other[30:0]};
      8, 9: x = {x[31], 8'(126 + $urandom_range(0, 2)), 19'd0, x[3:0]};
      default: ;
    endcase
    return x;
  endfunction

  function automatic vec_t mk(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic eq, input logic lt, input logic gt, input logic un,
                              input logic inv, input logic [31:0] res, input int gap);
    vec_t v;
    v.op  = op;
    v.a   = a;
    v.b   = b;
    v.e   = '{eq: eq, less: lt, great: gt, unord: un, inv: inv, res: res};
    v.gap = gap;
    return v;
  endfunction

  // One negedge: score the cycle, then drive the next input beat
  task automatic step(input logic a, input logic [1:0] o, input logic [31:0] x,
                      input logic [31:0] y, input exp_t e);
    sb_t it;
    @(negedge clk);
    cyc++;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      it = sb.pop_front();
      check("done", 64'(bus.done), 64'd1);
      check_out("result", it.e);
      last = it.e;
    end else begin
      check("idle_done", 64'(bus.done), 64'd0);
      check_out("hold", last);
    end
    rst     = 1'b0;
    bus.act = a;
    bus.op  = o;
    bus.in1 = x;
    bus.in2 = y;
    if (a) sb.push_back('{due: cyc + 3, e: e});
  endtask

  task automatic idle();
    step(1'b0, 2'($urandom), $urandom, $urandom, '0);
  endtask

  task automatic dvec(input logic [63:0] a, input logic [63:0] b, input logic eq,
                      input logic lt, input logic gt);
    @(negedge clk);
    dbus.act = 1'b1;
    dbus.op  = 2'd0;
    dbus.in1 = a;
    dbus.in2 = b;
    @(negedge clk);
    dbus.act = 1'b0;
    @(negedge clk);
    check("dp.early_done", 64'(dbus.done), 64'd0);
    @(negedge clk);
    check("dp.done", 64'(dbus.done), 64'd1);
    check("dp.eq", 64'(dbus.eq), 64'(eq));
    check("dp.less", 64'(dbus.less), 64'(lt));
    check("dp.great", 64'(dbus.great), 64'(gt));
    check("dp.unord", 64'(dbus.unord), 64'd0);
    check("dp.inv", 64'(dbus.inv), 64'd0);
    check("dp.res", dbus.res, 64'd0);
  endtask

  initial begin
    logic [1:0]  o;
    logic [31:0] x, y;

    rst      = 1'b1;
    last     = '0;
    bus.act  = 1'b0;
    bus.op   = '0;
    bus.in1  = '0;
    bus.in2  = '0;
    dbus.act = 1'b0;
    dbus.op  = '0;
    dbus.in1 = '0;
    dbus.in2 = '0;

    tbl.push_back(mk(2'd0, 32'h3F800000, 32'h40000000, 0, 1, 0, 0, 0, 32'h0, 3));
    tbl.push_back(mk(2'd0, 32'h00000000, 32'h80000000, 1, 0, 0, 0, 0, 32'h0, 3));
    tbl.push_back(mk(2'd2, 32'h00000000, 32'h80000000, 1, 0, 0, 0, 0, 32'h80000000, 3));
    tbl.push_back(mk(2'd3, 32'h00000000, 32'h80000000, 1, 0, 0, 0, 0, 32'h00000000, 3));
    tbl.push_back(mk(2'd0, 32'hFF800000, 32'hFF7FFFFF, 0, 1, 0, 0, 0, 32'h0, 3));
    tbl.push_back(mk(2'd0, 32'h7FC00000, 32'h3F800000, 0, 0, 0, 1, 0, 32'h0, 3));
    tbl.push_back(mk(2'd1, 32'h7FC00000, 32'h3F800000, 0, 0, 0, 1, 1, 32'h0, 3));
    tbl.push_back(mk(2'd0, 32'h7F800001, 32'h3F800000, 0, 0, 0, 1, 1, 32'h0, 3));
    tbl.push_back(mk(2'd2, 32'h7FC00000, 32'h3F800000, 0, 0, 0, 1, 0, 32'h3F800000, 3));
    tbl.push_back(mk(2'd3, 32'h7FC00000, 32'hFFC00000, 0, 0, 0, 1, 0, 32'h7FC00000, 3));
    tbl.push_back(mk(2'd2, 32'h7F800001, 32'hBF800000, 0, 0, 0, 1, 1, 32'hBF800000, 3));
    tbl.push_back(mk(2'd0, 32'h7F800000, 32'h7F800000, 1, 0, 0, 0, 0, 32'h0, 3));
`ifdef FP_COMP_DAZ_EN
    tbl.push_back(mk(2'd0, 32'h00000001, 32'h00000000, 1, 0, 0, 0, 0, 32'h0, 3));
`else
    tbl.push_back(mk(2'd0, 32'h00000001, 32'h00000000, 0, 0, 1, 0, 0, 32'h0, 3));
`endif
    tbl.push_back(mk(2'd0, 32'h3F800000, 32'h3F800000, 1, 0, 0, 0, 0, 32'h0, 0));
    tbl.push_back(mk(2'd3, 32'hC0000000, 32'h3F800000, 0, 1, 0, 0, 0, 32'h3F800000, 0));
    tbl.push_back(mk(2'd0, 32'hBF800000, 32'hC0000000, 0, 0, 1, 0, 0, 32'h0, 4));

    repeat (2) @(negedge clk);
    check("reset.done", 64'(bus.done), 64'd0);
    check_out("reset", '0);

    foreach (tbl[i]) begin
      step(1'b1, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].e);
      repeat (tbl[i].gap) idle();
    end

    // Reset while an operation is in flight: it must vanish
    step(1'b1, 2'd0, 32'h3F800000, 32'h40000000, model(2'd0, 32'h3F800000, 32'h40000000));
    @(negedge clk);
    cyc++;
    rst     = 1'b1;
    bus.act = 1'b0;
    #1;
    check("rst.done", 64'(bus.done), 64'd0);
    check_out("rst", '0);
    sb.delete();
    last = '0;
    step(1'b1, 2'd3, 32'h40400000, 32'hC0400000, model(2'd3, 32'h40400000, 32'hC0400000));
    repeat (4) idle();

    for (int i = 0; i < 400; i++) begin
      o = 2'($urandom);
      x = rnd_operand($urandom);
      y = rnd_operand(x);
      if ($urandom_range(0, 3) != 0) step(1'b1, o, x, y, model(o, x, y));
      else step(1'b0, o, x, y, '0);
    end
    repeat (5) idle();
    check("drain", 64'(sb.size()), 64'd0);

    dvec(64'h0000000000000001, 64'h0000000000000000,
`ifdef FP_COMP_DAZ_EN
         1'b1, 1'b0, 1'b0);
`else
         1'b0, 1'b0, 1'b1);
`endif
    dvec(64'h8000000000000001, 64'h0000000000000001,
`ifdef FP_COMP_DAZ_EN
         1'b1, 1'b0, 1'b0);
`else
         1'b0, 1'b1, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
